// File: rtl/rd_resp_buffer.sv
// Credit-managed FWFT response buffer behind the fixed-latency MMIO read pipeline.
// Credits bound reads in flight plus buffered words, so the unstallable pipeline never overflows.
module rd_resp_buffer #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [$clog2(DEPTH+1)-1:0] in_flight,
    output logic                       err
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    generate
        if (DEPTH < 1) begin : g_depth_check
            $error("rd_resp_buffer: DEPTH must be >= 1");
        end
    endgenerate

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW:0]      occupancy;
    logic             launch;
    logic             pop;
    logic             full;
    logic             push_ok;
    logic             overflow;
    logic             unsolicited;

    // One extra bit so count + in_flight cannot wrap before the compare.
    assign occupancy   = {1'b0, count} + {1'b0, in_flight};
    assign req_ready   = occupancy < (CW + 1)'(DEPTH);
    assign launch      = req_valid && req_ready;
    assign out_valid   = count != '0;
    assign out_data    = mem[rd_ptr];
    assign pop         = out_valid && out_ready;
    assign full        = count == CW'(DEPTH);
    assign push_ok     = in_valid && (!full || pop);
    assign overflow    = in_valid && full && !pop;
    assign unsolicited = in_valid && (in_flight == '0) && !launch;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            in_flight <= '0;
            err       <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= wrap_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= wrap_inc(rd_ptr);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (launch && !in_valid) begin
                in_flight <= in_flight + 1'b1;
            end else if (in_valid && !launch && in_flight != '0) begin
                in_flight <= in_flight - 1'b1;
            end
            if (overflow || unsolicited) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rd_resp_buffer.sv
// Bench for rd_resp_buffer: directed vector table, queue-model random streams,
// and hand-written full/overflow/reset sequences.
module tb_rd_resp_buffer;

    localparam int W = 8;
    localparam int D = 4;
    localparam int CW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready;
    logic [CW-1:0] count;
    logic [CW-1:0] in_flight;
    logic          err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    rd_resp_buffer #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .in_valid(in_valid),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready),
        .count(count),
        .in_flight(in_flight),
        .err(err)
    );

    typedef struct {
        logic         rv;
        logic         iv;
        logic [7:0]   id;
        logic         o;
        logic [CW-1:0] cnt;
        logic [CW-1:0] inf;
        logic         ov;
        logic [7:0]   od;
        logic         rr;
        logic         er;
    } vec_t;

    vec_t vecs[17];

    logic [7:0] mq[$];
    int         m_inf;
    logic       m_err;

    function automatic vec_t mk(input int rv, input int iv, input int id,
                                input int o, input int cnt, input int inf,
                                input int ov, input int od, input int rr,
                                input int er);
        vec_t m;
        m.rv  = rv[0];
        m.iv  = iv[0];
        m.id  = id[7:0];
        m.o   = o[0];
        m.cnt = cnt[CW-1:0];
        m.inf = inf[CW-1:0];
        m.ov  = ov[0];
        m.od  = od[7:0];
        m.rr  = rr[0];
        m.er  = er[0];
        return m;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rv, input logic iv,
                         input logic [7:0] d, input logic o);
        req_valid = rv;
        in_valid  = iv;
        in_data   = d;
        out_ready = o;
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        chk($sformatf("%s count", tag), count, mq.size());
        chk($sformatf("%s in_flight", tag), in_flight, m_inf);
        chk($sformatf("%s req_ready", tag), req_ready, (mq.size() + m_inf) < D);
        chk($sformatf("%s out_valid", tag), out_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            chk($sformatf("%s out_data", tag), out_data, mq[0]);
        end
        chk($sformatf("%s err", tag), err, m_err);
    endtask

    // Upstream obeys credits; a fixed-latency delay line returns each launch.
    task automatic run_stream(input int n, input int lat, input logic [7:0] base);
        logic       pv[8];
        logic [7:0] pd[8];
        int         sent;
        int         recv;
        int         cyc;
        logic       rv;
        logic       iv;
        logic       o;
        logic       ln;
        logic       pp;
        logic [7:0] d;
        logic [7:0] ld;
        sent = 0;
        recv = 0;
        cyc  = 0;
        for (int i = 0; i < 8; i++) begin
            pv[i] = 1'b0;
            pd[i] = 8'h00;
        end
        mq.delete();
        m_inf = 0;
        m_err = 1'b0;
        while (recv < n && cyc < 2000) begin
            check_model($sformatf("stream%0h c%0d", base, cyc));
            rv = (sent < n) && ($urandom_range(0, 1) != 0);
            iv = pv[lat-1];
            d  = pd[lat-1];
            o  = $urandom_range(0, 1) != 0;
            drive(rv, iv, d, o);
            ln = rv && ((mq.size() + m_inf) < D);
            ld = base + 8'(sent);
            if (ln) sent++;
            pp = o && (mq.size() != 0);
            if (iv && mq.size() == D && !pp) m_err = 1'b1;
            if (iv && m_inf == 0 && !ln) m_err = 1'b1;
            if (ln && !iv) m_inf++;
            else if (iv && !ln && m_inf > 0) m_inf--;
            if (pp) begin
                void'(mq.pop_front());
                recv++;
            end
            if (iv && mq.size() < D) mq.push_back(d);
            for (int i = 7; i > 0; i--) begin
                pv[i] = pv[i-1];
                pd[i] = pd[i-1];
            end
            pv[0] = ln;
            pd[0] = ld;
            tick;
            cyc++;
        end
        chk($sformatf("stream%0h words delivered", base), recv, n);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        check_model($sformatf("stream%0h end", base));
    endtask

    task automatic fill(input logic [7:0] base, input int nret);
        for (int i = 0; i < D; i++) begin
            drive(1'b1, 1'b0, 8'h00, 1'b0);
            tick;
        end
        for (int i = 0; i < nret; i++) begin
            drive(1'b0, 1'b1, base + 8'(i), 1'b0);
            tick;
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic drain_check(input string tag, input logic [7:0] e0,
                               input logic [7:0] e1, input logic [7:0] e2,
                               input logic [7:0] e3);
        logic [7:0] exp_q[4];
        exp_q = '{e0, e1, e2, e3};
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s out_valid %0d", tag, i), out_valid, 1'b1);
            chk($sformatf("%s out_data %0d", tag, i), out_data, exp_q[i]);
            drive(1'b0, 1'b0, 8'h00, 1'b1);
            tick;
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk($sformatf("%s empty after drain", tag), out_valid, 1'b0);
    endtask

    initial begin
        vecs[0]  = mk(1, 0, 'h00, 1, 0, 1, 0, 'h00, 1, 0);
        vecs[1]  = mk(0, 0, 'h00, 1, 0, 1, 0, 'h00, 1, 0);
        vecs[2]  = mk(0, 0, 'h00, 1, 0, 1, 0, 'h00, 1, 0);
        vecs[3]  = mk(0, 1, 'hA5, 1, 1, 0, 1, 'hA5, 1, 0);
        vecs[4]  = mk(0, 0, 'h00, 1, 0, 0, 0, 'h00, 1, 0);
        vecs[5]  = mk(1, 0, 'h00, 0, 0, 1, 0, 'h00, 1, 0);
        vecs[6]  = mk(1, 0, 'h00, 0, 0, 2, 0, 'h00, 1, 0);
        vecs[7]  = mk(1, 0, 'h00, 0, 0, 3, 0, 'h00, 1, 0);
        vecs[8]  = mk(1, 0, 'h00, 0, 0, 4, 0, 'h00, 0, 0);
        vecs[9]  = mk(1, 1, 'h01, 0, 1, 3, 1, 'h01, 0, 0);
        vecs[10] = mk(1, 1, 'h02, 0, 2, 2, 1, 'h01, 0, 0);
        vecs[11] = mk(1, 1, 'h03, 0, 3, 1, 1, 'h01, 0, 0);
        vecs[12] = mk(1, 1, 'h04, 0, 4, 0, 1, 'h01, 0, 0);
        vecs[13] = mk(0, 0, 'h00, 1, 3, 0, 1, 'h02, 1, 0);
        vecs[14] = mk(0, 0, 'h00, 1, 2, 0, 1, 'h03, 1, 0);
        vecs[15] = mk(0, 0, 'h00, 1, 1, 0, 1, 'h04, 1, 0);
        vecs[16] = mk(0, 0, 'h00, 1, 0, 0, 0, 'h00, 1, 0);

        rst = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        repeat (2) @(negedge clk);
        chk("reset count", count, 0);
        chk("reset in_flight", in_flight, 0);
        chk("reset out_valid", out_valid, 1'b0);
        chk("reset out_data", out_data, 8'h00);
        chk("reset req_ready", req_ready, 1'b1);
        chk("reset err", err, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].rv, vecs[i].iv, vecs[i].id, vecs[i].o);
            tick;
            chk($sformatf("vec%0d count", i), count, vecs[i].cnt);
            chk($sformatf("vec%0d in_flight", i), in_flight, vecs[i].inf);
            chk($sformatf("vec%0d out_valid", i), out_valid, vecs[i].ov);
            if (vecs[i].ov) begin
                chk($sformatf("vec%0d out_data", i), out_data, vecs[i].od);
            end
            chk($sformatf("vec%0d req_ready", i), req_ready, vecs[i].rr);
            chk($sformatf("vec%0d err", i), err, vecs[i].er);
        end
        drive(1'b0, 1'b0, 8'h00, 1'b0);

        run_stream(10, 3, 8'h10);
        run_stream(40, 1, 8'h40);
        run_stream(30, 5, 8'hC0);

        // Full FIFO, push and pop together; the push is unsolicited so err rises.
        fill(8'h31, 4);
        chk("full count", count, 4);
        chk("full in_flight", in_flight, 0);
        chk("full req_ready", req_ready, 1'b0);
        chk("full err before", err, 1'b0);
        drive(1'b0, 1'b1, 8'h55, 1'b1);
        tick;
        chk("pushpop count", count, 4);
        chk("pushpop in_flight", in_flight, 0);
        chk("pushpop err", err, 1'b1);
        drain_check("pushpop", 8'h32, 8'h33, 8'h34, 8'h55);

        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("unsol err cleared", err, 1'b0);
        drive(1'b0, 1'b1, 8'h77, 1'b0);
        tick;
        chk("unsol err", err, 1'b1);
        chk("unsol in_flight", in_flight, 0);
        chk("unsol count", count, 1);
        chk("unsol out_data", out_data, 8'h77);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        tick;
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk("unsol drained", count, 0);
        chk("unsol err sticky", err, 1'b1);

        rst = 1'b1;
        tick;
        rst = 1'b0;
        fill(8'h61, 4);
        chk("ovf pre err", err, 1'b0);
        chk("ovf pre count", count, 4);
        drive(1'b0, 1'b1, 8'hEE, 1'b0);
        tick;
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk("ovf count", count, 4);
        chk("ovf err", err, 1'b1);
        drain_check("ovf", 8'h61, 8'h62, 8'h63, 8'h64);
        repeat (3) tick;
        chk("ovf err sticky", err, 1'b1);

        // Asynchronous reset mid-cycle with words buffered and reads in flight.
        fill(8'h81, 2);
        chk("midrst pre count", count, 2);
        chk("midrst pre in_flight", in_flight, 2);
        chk("midrst pre err", err, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("midrst count", count, 0);
        chk("midrst in_flight", in_flight, 0);
        chk("midrst out_valid", out_valid, 1'b0);
        chk("midrst req_ready", req_ready, 1'b1);
        chk("midrst err", err, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b1, 8'h90, 1'b0);
        tick;
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk("late return err", err, 1'b1);
        chk("late return in_flight", in_flight, 0);
        chk("late return count", count, 1);
        chk("late return out_data", out_data, 8'h90);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
